// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-CTR sequencer: block width, default keystream
// queue depth and the controller state encoding.
package aes_ctr_pkg;

   localparam int BLOK_W              = 128;
   localparam int VARSAYILAN_DERINLIK = 4;

   typedef enum logic [1:0] {
      BOSTA  = 2'd0,
      CALIS  = 2'd1,
      BOSALT = 2'd2
   } durum_e;

endpackage

// File: rtl/aes_anahtar_fifo.sv
// Keystream FIFO: synchronous, power-of-two depth, with full/empty/count.
// A write while full is accepted only if a read happens in the same cycle.
module aes_anahtar_fifo
   import aes_ctr_pkg::*;
#(
   parameter int DERINLIK = VARSAYILAN_DERINLIK,
   parameter int SAYI_W   = $clog2(DERINLIK) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              yaz,
   input  logic [BLOK_W-1:0] yaz_veri,
   input  logic              oku,
   output logic [BLOK_W-1:0] bas_veri,
   output logic              dolu,
   output logic              bos,
   output logic [SAYI_W-1:0] sayi
);

   localparam int ADR_W = $clog2(DERINLIK);

   logic [BLOK_W-1:0] mem_q [DERINLIK];
   logic [BLOK_W-1:0] mem_d [DERINLIK];
   logic [ADR_W-1:0]  yaz_ptr_q, yaz_ptr_d;
   logic [ADR_W-1:0]  oku_ptr_q, oku_ptr_d;
   logic [SAYI_W-1:0] sayi_q, sayi_d;
   logic              yaz_ok, oku_ok;

   assign dolu     = (sayi_q == SAYI_W'(DERINLIK));
   assign bos      = (sayi_q == '0);
   assign sayi     = sayi_q;
   assign bas_veri = mem_q[oku_ptr_q];
   assign yaz_ok   = yaz && (!dolu || oku);
   assign oku_ok   = oku && !bos;

   always_comb begin
      mem_d     = mem_q;
      yaz_ptr_d = yaz_ptr_q;
      oku_ptr_d = oku_ptr_q;
      sayi_d    = sayi_q;
      if (yaz_ok) begin
         mem_d[yaz_ptr_q] = yaz_veri;
         yaz_ptr_d        = yaz_ptr_q + ADR_W'(1);
      end
      if (oku_ok) begin
         oku_ptr_d = oku_ptr_q + ADR_W'(1);
      end
      if (yaz_ok && !oku_ok) begin
         sayi_d = sayi_q + SAYI_W'(1);
      end else if (!yaz_ok && oku_ok) begin
         sayi_d = sayi_q - SAYI_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '{default: '0};
         yaz_ptr_q <= '0;
         oku_ptr_q <= '0;
         sayi_q    <= '0;
      end else begin
         mem_q     <= mem_d;
         yaz_ptr_q <= yaz_ptr_d;
         oku_ptr_q <= oku_ptr_d;
         sayi_q    <= sayi_d;
      end
   end

endmodule

// File: rtl/aes_ctr_denetleyici.sv
// CTR-mode sequencer in front of aes_engine: issues {nonce, sayac} blocks under
// a credit limit, queues the returned keystream and XORs it with plaintext.
module aes_ctr_denetleyici
   import aes_ctr_pkg::*;
#(
   parameter int KUYRUK_DERINLIK = VARSAYILAN_DERINLIK,
   parameter int SAYAC_W         = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      baslat,
   input  logic [BLOK_W-SAYAC_W-1:0] nonce,
   input  logic [SAYAC_W-1:0]        sayac_ilk,
   input  logic [15:0]               blok_sayisi,
   output logic [BLOK_W-1:0]         eng_blok,
   output logic                      eng_g_gecerli,
   input  logic                      eng_hazir,
   input  logic [BLOK_W-1:0]         eng_sifre,
   input  logic                      eng_c_gecerli,
   input  logic [BLOK_W-1:0]         acik_veri,
   input  logic                      acik_gecerli,
   output logic                      acik_hazir,
   output logic [BLOK_W-1:0]         cikis_veri,
   output logic                      cikis_gecerli,
   input  logic                      cikis_hazir,
   output logic                      mesgul,
   output logic                      bitti,
   output logic                      hata,
   output durum_e                    durum_dbg
);

   localparam int KREDI_W = $clog2(KUYRUK_DERINLIK) + 1;

   durum_e                    durum_q, durum_d;
   logic [BLOK_W-SAYAC_W-1:0] nonce_q, nonce_d;
   logic [SAYAC_W-1:0]        sayac_q, sayac_d;
   logic [15:0]               blok_sayisi_q, blok_sayisi_d;
   logic [15:0]               verilen_q, verilen_d;
   logic [15:0]               tamamlanan_q, tamamlanan_d;
   logic [KREDI_W-1:0]        kredi_q, kredi_d;
   logic [BLOK_W-1:0]         cikis_veri_q, cikis_veri_d;
   logic                      cikis_gecerli_q, cikis_gecerli_d;
   logic                      bitti_q, bitti_d;
   logic                      hata_q, hata_d;

   logic                      fifo_yaz, fifo_oku, fifo_dolu, fifo_bos;
   logic [BLOK_W-1:0]         fifo_bas;
   logic [KREDI_W-1:0]        fifo_sayi;
   logic                      verme, acik_al, cikis_ver, bekleyen;

   // Every interface moves a word on the rising edge where valid and ready are
   // both high; a raised valid and its data hold until that edge. The engine's
   // keystream return (eng_c_gecerli) is the exception: a bare pulse, no ready.
   assign eng_g_gecerli = (durum_q == CALIS) && (kredi_q != '0) && (verilen_q < blok_sayisi_q);
   assign eng_blok      = {nonce_q, sayac_q};
   assign verme         = eng_g_gecerli && eng_hazir;
   assign acik_hazir    = !fifo_bos && (!cikis_gecerli_q || cikis_hazir) && (durum_q != BOSTA);
   assign acik_al       = acik_gecerli && acik_hazir;
   assign cikis_ver     = cikis_gecerli_q && cikis_hazir;
   assign fifo_yaz      = eng_c_gecerli && (durum_q != BOSTA);
   assign fifo_oku      = acik_al;
   assign bekleyen      = (kredi_q != KREDI_W'(KUYRUK_DERINLIK)) || (fifo_sayi != '0);

   assign cikis_veri    = cikis_veri_q;
   assign cikis_gecerli = cikis_gecerli_q;
   assign mesgul        = (durum_q != BOSTA);
   assign bitti         = bitti_q;
   assign hata          = hata_q;
   assign durum_dbg     = durum_q;

   aes_anahtar_fifo #(
      .DERINLIK (KUYRUK_DERINLIK),
      .SAYI_W   (KREDI_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst),
      .yaz      (fifo_yaz),
      .yaz_veri (eng_sifre),
      .oku      (fifo_oku),
      .bas_veri (fifo_bas),
      .dolu     (fifo_dolu),
      .bos      (fifo_bos),
      .sayi     (fifo_sayi)
   );

   always_comb begin
      durum_d         = durum_q;
      nonce_d         = nonce_q;
      blok_sayisi_d   = blok_sayisi_q;
      sayac_d         = sayac_q + SAYAC_W'(verme);
      verilen_d       = verilen_q + 16'(verme);
      tamamlanan_d    = tamamlanan_q + 16'(cikis_ver);
      kredi_d         = kredi_q - KREDI_W'(verme) + KREDI_W'(cikis_ver);
      cikis_veri_d    = cikis_veri_q;
      cikis_gecerli_d = cikis_gecerli_q;
      bitti_d         = 1'b0;
      // Keystream in idle is only an error if an operation left work behind.
      hata_d          = hata_q
                      | (fifo_yaz && fifo_dolu && !fifo_oku)
                      | ((durum_q == BOSTA) && eng_c_gecerli && bekleyen);

      if (acik_al) begin
         cikis_veri_d    = acik_veri ^ fifo_bas;
         cikis_gecerli_d = 1'b1;
      end else if (cikis_ver) begin
         cikis_gecerli_d = 1'b0;
      end

      case (durum_q)
         BOSTA: begin
            if (baslat) begin
               nonce_d       = nonce;
               sayac_d       = sayac_ilk;
               blok_sayisi_d = blok_sayisi;
               verilen_d     = '0;
               tamamlanan_d  = '0;
               if (blok_sayisi == '0) begin
                  bitti_d = 1'b1;
               end else begin
                  durum_d = CALIS;
               end
            end
         end
         CALIS: begin
            if (verilen_d == blok_sayisi_q) begin
               durum_d = BOSALT;
            end
         end
         BOSALT: begin
            if (tamamlanan_d == blok_sayisi_q) begin
               bitti_d = 1'b1;
               durum_d = BOSTA;
            end
         end
         default: durum_d = BOSTA;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         durum_q         <= BOSTA;
         nonce_q         <= '0;
         sayac_q         <= '0;
         blok_sayisi_q   <= '0;
         verilen_q       <= '0;
         tamamlanan_q    <= '0;
         kredi_q         <= KREDI_W'(KUYRUK_DERINLIK);
         cikis_veri_q    <= '0;
         cikis_gecerli_q <= 1'b0;
         bitti_q         <= 1'b0;
         hata_q          <= 1'b0;
      end else begin
         durum_q         <= durum_d;
         nonce_q         <= nonce_d;
         sayac_q         <= sayac_d;
         blok_sayisi_q   <= blok_sayisi_d;
         verilen_q       <= verilen_d;
         tamamlanan_q    <= tamamlanan_d;
         kredi_q         <= kredi_d;
         cikis_veri_q    <= cikis_veri_d;
         cikis_gecerli_q <= cikis_gecerli_d;
         bitti_q         <= bitti_d;
         hata_q          <= hata_d;
      end
   end

endmodule

// File: tb/tb_aes_ctr_denetleyici.sv
// Directed bench for aes_ctr_denetleyici with a latency-modelled engine, a
// plaintext source, a sink and an expected-output queue.
module tb_aes_ctr_denetleyici;
   import aes_ctr_pkg::*;

   localparam int D       = 4;
   localparam int ENG_LAT = 3;
   localparam logic [127:0] NIST_CTR0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] NIST_CTR1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam logic [127:0] NIST_KS0  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
   localparam logic [127:0] NIST_KS1  = 128'h362b7c3c6773516318a077d7fc5073ae;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, baslat;
   logic [95:0]  nonce;
   logic [31:0]  sayac_ilk;
   logic [15:0]  blok_sayisi;
   logic [127:0] eng_blok, eng_sifre, acik_veri, cikis_veri;
   logic         eng_g_gecerli, eng_hazir, eng_c_gecerli;
   logic         acik_gecerli, acik_hazir, cikis_gecerli, cikis_hazir;
   logic         mesgul, bitti, hata;
   durum_e       durum_dbg;

   aes_ctr_denetleyici #(.KUYRUK_DERINLIK(D), .SAYAC_W(32)) dut (
      .clk(clk), .rst(rst), .baslat(baslat), .nonce(nonce), .sayac_ilk(sayac_ilk),
      .blok_sayisi(blok_sayisi), .eng_blok(eng_blok), .eng_g_gecerli(eng_g_gecerli),
      .eng_hazir(eng_hazir), .eng_sifre(eng_sifre), .eng_c_gecerli(eng_c_gecerli),
      .acik_veri(acik_veri), .acik_gecerli(acik_gecerli), .acik_hazir(acik_hazir),
      .cikis_veri(cikis_veri), .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir),
      .mesgul(mesgul), .bitti(bitti), .hata(hata), .durum_dbg(durum_dbg)
   );

   // ---------------- environment state ----------------
   int checks = 0, errors = 0;
   int cyc = 0;
   logic eng_hazir_rnd = 1'b0, sink_rnd = 1'b0, src_en = 1'b1, sink_en = 1'b1;
   logic zorla = 1'b0, hata_exp = 1'b0;
   logic [127:0] pipe_q[$];
   int           due_q[$];
   logic [127:0] pt_q[$];
   logic [127:0] exp_q[$];
   logic [127:0] exp_blok_q[$];
   int pt_idx = 0, issued = 0, outs = 0, bitti_count = 0, base_bitti = 0;
   int bitti_cyc = 0, last_out_cyc = 0, baslat_cyc = 0;
   logic eng_g_seen = 1'b0, mesgul_seen = 1'b0;
   logic prev_eng_stall = 1'b0, prev_out_stall = 1'b0;
   logic [127:0] prev_blok, prev_out;

   // Engine stand-in: real AES for the two NIST blocks, a keyed mix otherwise.
   function automatic logic [127:0] ks_model(input logic [127:0] b);
      if (b == NIST_CTR0) return NIST_KS0;
      if (b == NIST_CTR1) return NIST_KS1;
      return {b[63:0], ~b[127:64]} ^ 128'h0123456789abcdef_fedcba9876543210 ^ {4{b[31:0]}};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // ---------------- driver + per-cycle scoreboard ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      eng_c_gecerli = 1'b0;
      eng_sifre     = '0;
      if (zorla) begin
         eng_c_gecerli = 1'b1;
         eng_sifre     = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
         eng_c_gecerli = 1'b1;
         eng_sifre     = ks_model(pipe_q.pop_front());
         void'(due_q.pop_front());
      end
      eng_hazir    = eng_hazir_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acik_gecerli = src_en && (pt_idx < pt_q.size());
      acik_veri    = acik_gecerli ? pt_q[pt_idx] : '0;
      cikis_hazir  = sink_rnd ? 1'($urandom_range(0, 1)) : sink_en;
      #1;
      if (prev_eng_stall) begin
         check("eng_hold_valid", eng_g_gecerli, 1);
         check("eng_hold_blok", eng_blok, prev_blok);
      end
      if (prev_out_stall) begin
         check("out_hold_valid", cikis_gecerli, 1);
         check("out_hold_veri", cikis_veri, prev_out);
      end
      prev_eng_stall = eng_g_gecerli && !eng_hazir;
      prev_blok      = eng_blok;
      prev_out_stall = cikis_gecerli && !cikis_hazir;
      prev_out       = cikis_veri;
      if (eng_g_gecerli) eng_g_seen = 1'b1;
      if (mesgul) mesgul_seen = 1'b1;
      if (eng_g_gecerli && eng_hazir) begin
         if (exp_blok_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL eng_extra: actual issue %h required none", eng_blok);
         end else begin
            check("eng_blok", eng_blok, exp_blok_q.pop_front());
         end
         pipe_q.push_back(eng_blok);
         due_q.push_back(cyc + ENG_LAT);
         issued++;
      end
      if (acik_gecerli && acik_hazir) pt_idx++;
      if (cikis_gecerli && cikis_hazir) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_extra: actual %h required none", cikis_veri);
         end else begin
            check("cikis_veri", cikis_veri, exp_q.pop_front());
         end
         outs++;
         last_out_cyc = cyc;
      end
      if (bitti) begin
         bitti_count++;
         bitti_cyc = cyc;
         check("mesgul_at_bitti", mesgul, 0);
      end
      check("hata", hata, hata_exp);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      check("rst_eng_blok", eng_blok, 0);
      check("rst_eng_g_gecerli", eng_g_gecerli, 0);
      check("rst_acik_hazir", acik_hazir, 0);
      check("rst_cikis_veri", cikis_veri, 0);
      check("rst_cikis_gecerli", cikis_gecerli, 0);
      check("rst_mesgul", mesgul, 0);
      check("rst_bitti", bitti, 0);
      check("rst_hata", hata, 0);
      check("rst_durum", durum_dbg, BOSTA);
      hata_exp = 1'b0;
      exp_q.delete();
      exp_blok_q.delete();
      pt_q.delete();
      pt_idx = 0;
      prev_eng_stall = 1'b0;
      prev_out_stall = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
   endtask

   task automatic plan_model(input logic [95:0] n_in, input logic [31:0] s_in, input int n);
      pt_q.delete();
      exp_q.delete();
      exp_blok_q.delete();
      pt_idx = 0;
      for (int i = 0; i < n; i++) begin
         logic [127:0] ctr, pt;
         ctr = {n_in, s_in + 32'(i)};
         pt  = {4{32'h0badf00d + 32'(i) * 32'h01010101}};
         pt_q.push_back(pt);
         exp_blok_q.push_back(ctr);
         exp_q.push_back(pt ^ ks_model(ctr));
      end
   endtask

   task automatic start_op(input logic [95:0] n_in, input logic [31:0] s_in, input int n);
      nonce       = n_in;
      sayac_ilk   = s_in;
      blok_sayisi = 16'(n);
      baslat      = 1'b1;
      base_bitti  = bitti_count;
      issued      = 0;
      outs        = 0;
      eng_g_seen  = 1'b0;
      mesgul_seen = 1'b0;
      baslat_cyc  = cyc;
      tick();
      baslat = 1'b0;
      check("first_issue", eng_g_seen, (n != 0));
      check("mesgul_after_baslat", mesgul, (n != 0));
   endtask

   task automatic wait_done(input int budget, input int n);
      int k;
      k = 0;
      while (bitti_count == base_bitti && k < budget) begin
         tick();
         k++;
      end
      if (bitti_count == base_bitti) begin
         checks++;
         errors++;
         $display("FAIL bitti_timeout: actual no bitti after %0d cycles required bitti", budget);
      end else begin
         check("bitti_timing", bitti_cyc, last_out_cyc + 1);
      end
      repeat (3) tick();
      check("bitti_once", bitti_count - base_bitti, 1);
      check("outs_count", outs, n);
      check("exp_left", exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1; baslat = 1'b0; nonce = '0; sayac_ilk = '0; blok_sayisi = '0;
      eng_hazir = 1'b0; eng_sifre = '0; eng_c_gecerli = 1'b0;
      acik_veri = '0; acik_gecerli = 1'b0; cikis_hazir = 1'b0;
      #2;
      apply_reset();

      // 1: NIST SP800-38A F.5.1, two blocks, random engine and sink stalls
      pt_q.delete(); exp_q.delete(); exp_blok_q.delete(); pt_idx = 0;
      pt_q.push_back(128'h6bc1bee22e409f96e93d7e117393172a);
      pt_q.push_back(128'hae2d8a571e03ac9c9eb76fac45af8e51);
      exp_q.push_back(128'h874d6191b620e3261bef6864990db6ce);
      exp_q.push_back(128'h9806f66b7970fdff8617187bb9fffdff);
      exp_blok_q.push_back(NIST_CTR0);
      exp_blok_q.push_back(NIST_CTR1);
      eng_hazir_rnd = 1'b1; sink_rnd = 1'b1;
      start_op(96'hf0f1f2f3f4f5f6f7f8f9fafb, 32'hfcfdfeff, 2);
      wait_done(300, 2);

      // 2: counter wrap, low words pinned to literals
      plan_model(96'h0123456789abcdef01234567, 32'hffffffff, 3);
      exp_blok_q.delete();
      exp_blok_q.push_back({96'h0123456789abcdef01234567, 32'hffffffff});
      exp_blok_q.push_back({96'h0123456789abcdef01234567, 32'h00000000});
      exp_blok_q.push_back({96'h0123456789abcdef01234567, 32'h00000001});
      start_op(96'h0123456789abcdef01234567, 32'hffffffff, 3);
      wait_done(300, 3);
      eng_hazir_rnd = 1'b0; sink_rnd = 1'b0;

      // 3: sink blocked for 20 cycles, credit limits issue to the FIFO depth
      plan_model(96'hcafef00dcafef00dcafef00d, 32'h00000010, 8);
      sink_en = 1'b0;
      start_op(96'hcafef00dcafef00dcafef00d, 32'h00000010, 8);
      repeat (19) tick();
      check("issued_before_out", issued, D);
      check("outs_while_blocked", outs, 0);
      sink_en = 1'b1;
      wait_done(300, 8);

      // 4: zero-length operation
      plan_model(96'h1, 32'h0, 0);
      start_op(96'h1, 32'h0, 0);
      check("bitti_after_baslat", bitti_cyc, baslat_cyc + 1);
      repeat (4) tick();
      check("bitti_zero_once", bitti_count - base_bitti, 1);
      check("zero_no_issue", eng_g_seen, 0);
      check("zero_no_mesgul", mesgul_seen, 0);

      // 5: reset after two issued blocks, late keystream dropped, then fresh run
      plan_model(96'h5555aaaa5555aaaa5555aaaa, 32'h00000100, 5);
      start_op(96'h5555aaaa5555aaaa5555aaaa, 32'h00000100, 5);
      for (int k = 0; k < 20 && issued < 2; k++) tick();
      check("issued_before_reset", issued, 2);
      apply_reset();
      check("no_bitti_on_reset", bitti_count - base_bitti, 0);
      check("pipe_drained", pipe_q.size(), 0);
      plan_model(96'h77777777888888889999999a, 32'h7ffffffe, 3);
      start_op(96'h77777777888888889999999a, 32'h7ffffffe, 3);
      wait_done(300, 3);

      // 6: forced keystream into a full FIFO
      plan_model(96'hdeadbeefdeadbeefdeadbeef, 32'h00000040, 4);
      src_en = 1'b0; sink_en = 1'b0;
      start_op(96'hdeadbeefdeadbeefdeadbeef, 32'h00000040, 4);
      repeat (12) tick();
      check("full_before_force", pipe_q.size(), 0);
      zorla = 1'b1;
      tick();
      zorla = 1'b0;
      hata_exp = 1'b1;
      tick();
      src_en = 1'b1; sink_en = 1'b1;
      wait_done(300, 4);
      repeat (5) tick();
      apply_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_ctr_denetleyici.md
Name: aes_ctr_denetleyici

Overview:
CTR-mode sequencer that sits in front of aes_engine.
- Generates counter blocks {nonce, sayac} and issues them to the engine over its g_gecerli/hazir handshake.
- Buffers the keystream the engine returns and XORs it with incoming plaintext words to produce ciphertext, or plaintext when decrypting.
- aes_engine has no output backpressure, so the controller admits blocks against a credit count and can never overflow its keystream buffer.

Parameters:
KUYRUK_DERINLIK, 4, keystream FIFO depth; also the maximum number of blocks in flight plus buffered (power of 2, ≥2).
SAYAC_W, 32, width of the incrementing counter field; the nonce is 128-SAYAC_W bits.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
baslat  in  1  start pulse; sampled only in BOSTA.
nonce  in  128-SAYAC_W  fixed upper part of the counter block; latched on baslat.
sayac_ilk  in  SAYAC_W  initial counter value; latched on baslat.
blok_sayisi  in  16  number of blocks to process; latched on baslat.
eng_blok  out  128  counter block sent to the engine.
eng_g_gecerli  out  1  counter block valid.
eng_hazir  in  1  engine accepts the block.
eng_sifre  in  128  keystream from the engine.
eng_c_gecerli  in  1  keystream valid; one-cycle pulse, no backpressure.
acik_veri  in  128  plaintext word.
acik_gecerli  in  1  plaintext valid.
acik_hazir  out  1  plaintext accepted.
cikis_veri  out  128  acik_veri XOR keystream.
cikis_gecerli  out  1  output valid.
cikis_hazir  in  1  downstream accepts the output.
mesgul  out  1  high from baslat acceptance until bitti.
bitti  out  1  one-cycle completion pulse.
hata  out  1  sticky flag: keystream arrived while the FIFO was full, or in BOSTA with pending work.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to BOSTA.
  - All outputs are 0, including eng_blok and cikis_veri.
  - FIFO is emptied; credit is set to KUYRUK_DERINLIK; hata is cleared.
- Reset mid-operation: the operation is abandoned. No bitti is generated. Engine results arriving afterwards in BOSTA are dropped without setting hata.
- State BOSTA:
  - On baslat=1, latch nonce, sayac_ilk and blok_sayisi; clear the issue and output counters.
  - If blok_sayisi≠0, go to CALIS and raise mesgul in the next cycle.
  - If blok_sayisi=0, pulse bitti in the next cycle, stay in BOSTA, and keep mesgul at 0.
- State CALIS:
  - eng_g_gecerli=1 when credit>0 and verilen<blok_sayisi. The first assertion occurs 1 cycle after baslat.
  - eng_blok={nonce, sayac} stays stable while eng_g_gecerli=1 and eng_hazir=0.
  - On a transfer (eng_g_gecerli & eng_hazir): sayac increments mod 2^SAYAC_W (wraps, nonce unchanged), verilen increments, credit decrements.
  - When verilen reaches blok_sayisi, go to BOSALT.
- State BOSALT: no more issues. When tamamlanan==blok_sayisi, pulse bitti, drop mesgul and go to BOSTA, all in the same cycle.
- Keystream FIFO:
  - eng_c_gecerli pushes eng_sifre.
  - A push while the FIFO is full is dropped and sets hata. This cannot occur if the engine honours credits.
- Pairing and output:
  - acik_hazir = FIFO non-empty & (cikis_gecerli=0 | cikis_hazir) & state≠BOSTA.
  - On an acik transfer: pop the FIFO, and register cikis_veri = acik_veri ^ FIFO head with cikis_gecerli=1 in the next cycle.
- Output register hold: cikis_veri and cikis_gecerli stay held until cikis_hazir.
- Output transfer: increments tamamlanan and credit.
- Simultaneous issue and credit return: credit is unchanged.
- Simultaneous push and pop: FIFO count is unchanged; a push when full that coincides with a pop is legal.
- Ordering: blocks complete in order. The engine is in-order, so the FIFO preserves counter order.
- Throughput: with the engine, source and sink all always ready, the block sustains 1 block per cycle.
- bitti timing: occurs 1 cycle after the last output transfer.

Decomposition:
- Shared package aes_ctr_pkg:
  - state encoding BOSTA/CALIS/BOSALT;
  - BLOK_W=128 constant;
  - default KUYRUK_DERINLIK.
- One sub-module: aes_anahtar_fifo, a synchronous FIFO of depth KUYRUK_DERINLIK with full/empty/count outputs.

Test Plan:
1. NIST SP800-38A F.5.1 (key 2b7e151628aed2a6abf7158809cf4f3c), nonce f0f1f2f3f4f5f6f7f8f9fafb, sayac_ilk fcfdfeff, 2 blocks.
   - Stimulus: plaintext 6bc1bee22e409f96e93d7e117393172a, then ae2d8a571e03ac9c9eb76fac45af8e51.
   - Required: cikis 874d6191b620e3261bef6864990db6ce, then 9806f66b7970fdff8617187bb9fffdff; one bitti pulse.
2. sayac_ilk ffffffff, 3 blocks -> eng_blok low words ffffffff, 00000000, 00000001; nonce unchanged.
3. cikis_hazir=0 for 20 cycles with KUYRUK_DERINLIK=4, 8 blocks -> at most 4 blocks issued before any output; hata stays 0; all 8 outputs arrive in order after release.
4. blok_sayisi=0 -> bitti exactly 1 cycle after baslat; eng_g_gecerli never rises; mesgul stays 0.
5. rst=0 asserted after 2 of 5 blocks issued -> all outputs 0 immediately; late eng_c_gecerli ignored; a fresh baslat then processes correctly.
6. Forced eng_c_gecerli with FIFO full -> hata=1 and stays 1 until reset; FIFO contents unchanged.
